// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the rotate-unit state encoding.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } ror_state_e;

endpackage

// File: rtl/alu_ror_step.sv
// Combinational rotate of a WIDTH-bit value by 0..2**AMT_W-1 bits.
// Right-only by default; ALU_ROR_ROL_EN adds a left-rotate direction input.
module alu_ror_step #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [AMT_W-1:0] amt_i,
`ifdef ALU_ROR_ROL_EN
    input  logic             dir_left_i,
`endif
    output logic [WIDTH-1:0] val_o
);

    // A shift by WIDTH yields zero, so amt_i == 0 passes val_i through unchanged.
    logic [WIDTH-1:0] ror_val;
    assign ror_val = (val_i >> amt_i) | (val_i << (WIDTH - int'(amt_i)));

`ifdef ALU_ROR_ROL_EN
    logic [WIDTH-1:0] rol_val;
    assign rol_val = (val_i << amt_i) | (val_i >> (WIDTH - int'(amt_i)));
    assign val_o   = dir_left_i ? rol_val : ror_val;
`else
    assign val_o   = ror_val;
`endif

endmodule

// File: rtl/alu_ror_seq.sv
// Multi-cycle rotate unit: rotates right by num_rotates, up to STEP bits per clock,
// under a start/busy/done handshake. ALU_ROR_ROL_EN adds a dir_left input for left rotates.
module alu_ror_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W,
    parameter int STEP    = 1
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_input,
    input  logic [SHAMT_W-1:0] num_rotates,
`ifdef ALU_ROR_ROL_EN
    input  logic               dir_left,
`endif
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_output
);

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    ror_state_e         state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W-1:0] rem_nxt;
    logic [WIDTH-1:0]   step_val;

`ifdef ALU_ROR_ROL_EN
    logic dir_q, dir_d;
`endif

    assign k       = (rem_q < STEP_C) ? rem_q : STEP_C;
    assign rem_nxt = rem_q - k;

    alu_ror_step #(
        .WIDTH (WIDTH),
        .AMT_W (SHAMT_W)
    ) u_step (
        .val_i      (work_q),
        .amt_i      (k),
`ifdef ALU_ROR_ROL_EN
        .dir_left_i (dir_q),
`endif
        .val_o      (step_val)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        out_d   = out_q;
`ifdef ALU_ROR_ROL_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = data_input;
                    rem_d  = num_rotates;
`ifdef ALU_ROR_ROL_EN
                    dir_d  = dir_left;
`endif
                    // A zero count skips ROTATE, so the result is published right away.
                    if (num_rotates == '0) begin
                        state_d = DONE;
                        out_d   = data_input;
                    end else begin
                        state_d = ROTATE;
                    end
                end
            end
            ROTATE: begin
                work_d = step_val;
                rem_d  = rem_nxt;
                if (rem_nxt == '0) begin
                    state_d = DONE;
                    out_d   = step_val;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
`ifdef ALU_ROR_ROL_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
`ifdef ALU_ROR_ROL_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign data_output = out_q;

endmodule
